ssm_mux_word_packer: RTL and testbench

- Encoder-side substream multiplexer. It turns four per-substream word streams (ssm0..ssm3) into the single 128-bit bitstream word sequence that the decoder's four bitparse instances consume.
- It emits mux words in the exact order the decoder's read arbitration expects. Within one cycle, requests are serviced in ascending substream index; across cycles, requests are serviced in arrival order.
- It sits between the four substream encoders and the rate-buffer/bitstream writer.

---
 rtl/ssm_mux_word_packer.sv | 185 ++++++++++++++++++
 tb/tb_ssm_mux_word_packer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssm_mux_word_packer.sv
// Substream mux word packer: four per-substream word FIFOs drained in decoder read order.
// Optional end-of-slice flush/drain support is compiled in with SSM_MUX_FLUSH_EN.
module ssm_mux_word_packer #(
    parameter int DW         = 128,
    parameter int FIFO_DEPTH = 8,
    parameter int REQ_DEPTH  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    ssm_wr_en,
    input  logic [DW-1:0] ssm_wr_data_0,
    input  logic [DW-1:0] ssm_wr_data_1,
    input  logic [DW-1:0] ssm_wr_data_2,
    input  logic [DW-1:0] ssm_wr_data_3,
    output logic [3:0]    ssm_full,
    input  logic [3:0]    mux_req,
    output logic          req_full,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
`ifdef SSM_MUX_FLUSH_EN
    input  logic          flush,
    output logic          flush_done,
`endif
    output logic          err_ovf,
    output logic          idle
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int RAW = $clog2(REQ_DEPTH);

    logic [3:0][DW-1:0] wr_data_v, rd_data_v;
    logic [3:0]         fifo_rd, fifo_empty, fifo_ovf;

    assign wr_data_v = {ssm_wr_data_3, ssm_wr_data_2, ssm_wr_data_1, ssm_wr_data_0};

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [DW-1:0]  mem [FIFO_DEPTH];
        logic [FAW-1:0] wp, rp;
        logic [FAW:0]   cnt, cnt_nxt;
        logic           wr_ok, rd_ok, full_r;

        // a full FIFO refuses the write even when it is popped in the same cycle
        assign wr_ok         = ssm_wr_en[g] && (cnt != (FAW+1)'(FIFO_DEPTH));
        assign rd_ok         = fifo_rd[g] && (cnt != '0);
        assign cnt_nxt       = cnt + (FAW+1)'(wr_ok) - (FAW+1)'(rd_ok);
        assign fifo_empty[g] = (cnt == '0);
        assign fifo_ovf[g]   = ssm_wr_en[g] && !wr_ok;
        assign rd_data_v[g]  = mem[rp];
        assign ssm_full[g]   = full_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp     <= '0;
                rp     <= '0;
                cnt    <= '0;
                full_r <= 1'b0;
            end else begin
                if (wr_ok) wp <= wp + 1'b1;
                if (rd_ok) rp <= rp + 1'b1;
                cnt    <= cnt_nxt;
                full_r <= (cnt_nxt == (FAW+1)'(FIFO_DEPTH));
            end
        end

        always_ff @(posedge clk) begin
            if (wr_ok) mem[wp] <= wr_data_v[g];
        end
    end

    logic [1:0]   req_q [REQ_DEPTH];
    logic [RAW-1:0] req_wp, req_rp;
    logic [RAW:0] req_cnt, req_cnt_nxt, req_free;
    logic [3:0]   req_eff;
    logic [1:0]   off [4];
    logic [2:0]   pc;
    logic [1:0]   first_id, head_id, issue_sel;
    logic         flushing, req_accept, req_drop, flush_err;
    logic         head_vld, slot_free, q_pop, issue;

`ifdef SSM_MUX_FLUSH_EN
    typedef enum logic [1:0] {S_NORM, S_FLUSH, S_DONE} state_t;
    state_t state, state_nxt;
    logic [1:0] drain_id;
    logic       drain_issue;

    assign flushing   = flush || (state == S_FLUSH);
    assign flush_done = (state == S_DONE);

    always_comb begin
        drain_id = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (!fifo_empty[k]) drain_id = 2'(k);
    end
    assign drain_issue = (state == S_FLUSH) && (req_cnt == '0) && !(&fifo_empty) && slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_NORM;
        else     state <= state_nxt;
    end

    // done once the queue and FIFOs are dry and the output register has handed off its word
    always_comb begin
        state_nxt = state;
        case (state)
            S_NORM:  if (flush) state_nxt = S_FLUSH;
            S_FLUSH: if ((req_cnt == '0) && (&fifo_empty) && slot_free) state_nxt = S_DONE;
            default: state_nxt = S_NORM;
        endcase
    end
`else
    assign flushing = 1'b0;
`endif

    assign req_eff = flushing ? 4'b0 : mux_req;

    // per-bit slot offsets so set bits land in ascending substream order
    always_comb begin
        logic [2:0] acc;
        acc      = 3'd0;
        first_id = 2'd0;
        for (int k = 0; k < 4; k++) begin
            off[k] = acc[1:0];
            acc    = acc + 3'(req_eff[k]);
        end
        for (int k = 3; k >= 0; k--)
            if (req_eff[k]) first_id = 2'(k);
        pc = acc;
    end

    assign req_free   = (RAW+1)'(REQ_DEPTH) - req_cnt;
    assign req_accept = (pc != 3'd0) && ((RAW+1)'(pc) <= req_free);
    assign req_drop   = (pc != 3'd0) && !req_accept;
    assign flush_err  = flushing && (mux_req != 4'b0);

    // an empty queue lets this cycle's first request issue straight through
    assign head_id   = (req_cnt == '0) ? first_id : req_q[req_rp];
    assign head_vld  = (req_cnt != '0) || req_accept;
    assign slot_free = !out_vld || out_rdy;
    assign q_pop     = head_vld && !fifo_empty[head_id] && slot_free;

    always_comb begin
        issue_sel = head_id;
        issue     = q_pop;
`ifdef SSM_MUX_FLUSH_EN
        if (drain_issue) begin
            issue_sel = drain_id;
            issue     = 1'b1;
        end
`endif
        fifo_rd = issue ? (4'b0001 << issue_sel) : 4'b0000;
    end

    assign req_cnt_nxt = req_cnt + (req_accept ? (RAW+1)'(pc) : '0) - (RAW+1)'(q_pop);

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (req_accept && req_eff[k]) req_q[req_wp + RAW'(off[k])] <= 2'(k);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_wp   <= '0;
            req_rp   <= '0;
            req_cnt  <= '0;
            req_full <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= '0;
            err_ovf  <= 1'b0;
        end else begin
            if (req_accept) req_wp <= req_wp + RAW'(pc);
            if (q_pop)      req_rp <= req_rp + 1'b1;
            req_cnt  <= req_cnt_nxt;
            req_full <= (((RAW+1)'(REQ_DEPTH) - req_cnt_nxt) < (RAW+1)'(4));
            if (issue) begin
                out_vld  <= 1'b1;
                out_data <= rd_data_v[issue_sel];
            end else if (out_rdy) begin
                out_vld  <= 1'b0;
            end
            err_ovf <= err_ovf | (|fifo_ovf) | req_drop | flush_err;
        end
    end

    assign idle = (req_cnt == '0) && !out_vld;
endmodule

// File: tb/tb_ssm_mux_word_packer.sv
// Scoreboard bench for ssm_mux_word_packer: request ids queued at stimulus, words checked at transfer.
module tb_ssm_mux_word_packer;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    ssm_wr_en = '0;
    logic [3:0][DW-1:0] wd = '0;
    logic [3:0]    ssm_full;
    logic [3:0]    mux_req = '0;
    logic          req_full, out_vld, err_ovf, idle;
    logic          out_rdy = 1'b1;
    logic [DW-1:0] out_data;
`ifdef SSM_MUX_FLUSH_EN
    logic          flush = 1'b0;
    logic          flush_done;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fm [4][$];
    int            id_q [$];

    ssm_mux_word_packer #(.DW(DW), .FIFO_DEPTH(8), .REQ_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .ssm_wr_en(ssm_wr_en),
        .ssm_wr_data_0(wd[0]), .ssm_wr_data_1(wd[1]),
        .ssm_wr_data_2(wd[2]), .ssm_wr_data_3(wd[3]),
        .ssm_full(ssm_full), .mux_req(mux_req), .req_full(req_full),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
`ifdef SSM_MUX_FLUSH_EN
        .flush(flush), .flush_done(flush_done),
`endif
        .err_ovf(err_ovf), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input int k, input int n);
        return {32'(k), 32'(n), 32'hC0DE0000 + 32'(k * 16 + n), 32'hFEED0000};
    endfunction

    // transfers are sampled on the falling edge, inputs only move just after the rising edge
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            checks++;
            if (id_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got word %h, want no transfer", out_data);
            end else begin
                automatic int id = id_q.pop_front();
                if (fm[id].size() == 0) begin
                    errors++;
                    $display("FAIL sb_model_empty: got word %h for id %0d, want none", out_data, id);
                end else begin
                    automatic logic [DW-1:0] exp = fm[id].pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL sb_word: got %h, want %h (id %0d)", out_data, exp, id);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int k = 0; k < 4; k++) fm[k].delete();
        id_q.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [3:0] en, input int n);
        ssm_wr_en = en;
        for (int k = 0; k < 4; k++) begin
            wd[k] = mk(k, n);
            if (en[k] && fm[k].size() < 8) fm[k].push_back(mk(k, n));
        end
        tick();
        ssm_wr_en = '0;
    endtask

    task automatic req(input logic [3:0] r, input bit accepted);
        mux_req = r;
        if (accepted)
            for (int k = 0; k < 4; k++) if (r[k]) id_q.push_back(k);
        tick();
        mux_req = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && (id_q.size() != 0 || out_vld); i++) tick();
        checks++;
        if (id_q.size() != 0 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending, out_vld=%b, want 0 pending, out_vld=0",
                     name, id_q.size(), out_vld);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (out_vld !== 1'b0 || out_data !== '0 || err_ovf !== 1'b0 || ssm_full !== 4'b0 ||
            req_full !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got vld=%b data=%h err=%b full=%b rfull=%b idle=%b, want 0,0,0,0,0,1",
                     out_vld, out_data, err_ovf, ssm_full, req_full, idle);
        end
    endtask

    task automatic test_order_one_cycle;
        logic [DW-1:0] exp;
        out_rdy = 1'b1;
        wr(4'b1111, 0);
        req(4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp = mk(i, 0);
            checks++;
            if (out_vld !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL order_cycle%0d: got vld=%b data=%h, want vld=1 data=%h", i, out_vld, out_data, exp);
            end
            tick();
        end
        wait_drain("order");
    endtask

    task automatic test_two_requests;
        logic [DW-1:0] exp [3];
        exp[0] = mk(1, 1);
        exp[1] = mk(2, 1);
        exp[2] = mk(0, 1);
        wr(4'b1111, 1);
        req(4'b0110, 1'b1);
        checks++;
        if (out_data !== exp[0]) begin
            errors++;
            $display("FAIL two_req_first: got %h, want %h", out_data, exp[0]);
        end
        req(4'b0001, 1'b1);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (out_vld !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL two_req_%0d: got vld=%b data=%h, want vld=1 data=%h", i, out_vld, out_data, exp[i]);
            end
            tick();
        end
        wait_drain("two_req");
    endtask

    task automatic test_head_stall;
        int early;
        wr(4'b0001, 2);
        req(4'b0100, 1'b1);
        req(4'b0001, 1'b1);
        early = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_vld !== 1'b0) early++;
            tick();
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL head_stall_pass: got %0d cycles with out_vld=1, want 0", early);
        end
        wr(4'b0100, 2);
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL head_stall_early: got out_vld=%b one cycle after write, want 0", out_vld);
        end
        tick();
        checks++;
        if (out_vld !== 1'b1 || out_data !== mk(2, 2)) begin
            errors++;
            $display("FAIL head_stall_lat: got vld=%b data=%h, want vld=1 data=%h", out_vld, out_data, mk(2, 2));
        end
        wait_drain("head_stall");
    endtask

    task automatic test_backpressure;
        int bad;
        out_rdy = 1'b0;
        wr(4'b0010, 3);
        wr(4'b0010, 4);
        req(4'b0010, 1'b1);
        req(4'b0010, 1'b1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_vld !== 1'b1 || out_data !== mk(1, 3)) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles, want 0 (word %h)", bad, mk(1, 3));
        end
        out_rdy = 1'b1;
        tick();
        checks++;
        if (out_vld !== 1'b1 || out_data !== mk(1, 4)) begin
            errors++;
            $display("FAIL bp_next: got vld=%b data=%h, want vld=1 data=%h", out_vld, out_data, mk(1, 4));
        end
        wait_drain("bp");
    endtask

    task automatic test_fifo_overflow;
        for (int n = 0; n < 8; n++) wr(4'b0100, 10 + n);
        checks++;
        if (ssm_full !== 4'b0100 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: got full=%b err=%b, want full=0100 err=0", ssm_full, err_ovf);
        end
        wr(4'b0100, 99);
        checks++;
        if (err_ovf !== 1'b1 || ssm_full !== 4'b0100) begin
            errors++;
            $display("FAIL fifo_ovf: got err=%b full=%b, want err=1 full=0100", err_ovf, ssm_full);
        end
    endtask

    task automatic test_req_overflow;
        do_reset();
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reqovf_clear: got err=%b after reset, want 0", err_ovf);
        end
        for (int i = 0; i < 12; i++) req(4'b1000, 1'b1);
        checks++;
        if (req_full !== 1'b0) begin
            errors++;
            $display("FAIL req_full_12: got %b with 12 queued, want 0", req_full);
        end
        req(4'b1000, 1'b1);
        checks++;
        if (req_full !== 1'b1 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL req_full_13: got rfull=%b err=%b, want rfull=1 err=0", req_full, err_ovf);
        end
        req(4'b1111, 1'b0);
        checks++;
        if (err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL req_drop: got err=%b, want 1", err_ovf);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (err_ovf !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: got err=%b idle=%b, want err=1 idle=0", err_ovf, idle);
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        out_rdy = 1'b0;
        wr(4'b0001, 20);
        req(4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) req(4'b1000, 1'b1);
        checks++;
        if (out_vld !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: got vld=%b idle=%b, want vld=1 idle=0", out_vld, idle);
        end
        rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (out_vld !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got vld=%b idle=%b, want vld=0 idle=1", out_vld, idle);
        end
        tick();
        rst = 1'b0;
        tick();
        out_rdy = 1'b1;
        wr(4'b1001, 21);
        req(4'b1001, 1'b1);
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_order_one_cycle();
        test_two_requests();
        test_head_stall();
        test_backpressure();
        test_fifo_overflow();
        test_req_overflow();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
